// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Optional same-cycle writeback forwarding: define REGFILE_BYPASS_EN.
module regfile_rename #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_WB   = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      inst_valid,
  input  logic [$clog2(NUM_REGS)-1:0] rs1,
  input  logic [$clog2(NUM_REGS)-1:0] rs2,
  input  logic [$clog2(NUM_REGS)-1:0] rd,
  input  logic [TAG_W-1:0]          rd_tag,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
  input  logic [NUM_WB*XLEN-1:0]    wb_val,
  input  logic                      flush_in,
  output logic [XLEN-1:0]           vj,
  output logic [XLEN-1:0]           vk,
  output logic [TAG_W-1:0]          qj,
  output logic [TAG_W-1:0]          qk,
  output logic [$clog2(NUM_REGS):0] busy_cnt
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int BW = RW + 1;

  logic [XLEN-1:0]  val_q [NUM_REGS];
  logic [XLEN-1:0]  val_n [NUM_REGS];
  logic [TAG_W-1:0] tag_q [NUM_REGS];
  logic [TAG_W-1:0] tag_n [NUM_REGS];
  logic [BW-1:0]    busy_q;
  logic [BW-1:0]    busy_n;

  logic [RW-1:0]    rs_a [2];
  logic [XLEN-1:0]  v_o  [2];
  logic [TAG_W-1:0] q_o  [2];

  assign rs_a[0]  = rs1;
  assign rs_a[1]  = rs2;
  assign vj       = v_o[0];
  assign vk       = v_o[1];
  assign qj       = q_o[0];
  assign qk       = q_o[1];
  assign busy_cnt = busy_q;

  // Next state: writeback retire, then flush or rename, then popcount
  always_comb begin
    val_n  = val_q;
    tag_n  = tag_q;
    busy_n = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      // descending scan so the lowest channel has the final say
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_valid[k] &&
            wb_tag[k*TAG_W +: TAG_W] != '0 &&
            tag_q[i] == wb_tag[k*TAG_W +: TAG_W]) begin
          val_n[i] = wb_val[k*XLEN +: XLEN];
          tag_n[i] = '0;
        end
      end
    end
    if (flush_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_n[i] = '0;
      end
    end else if (inst_valid && rd != '0) begin
      tag_n[rd] = rd_tag;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (tag_n[i] != '0) begin
        busy_n = busy_n + BW'(1);
      end
    end
  end

  // State registers; rdy_in low holds everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= val_n[i];
        tag_q[i] <= tag_n[i];
      end
      busy_q <= busy_n;
    end
  end

  // Operand read ports, with optional forwarding from the writeback bus
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_o[p] = '0;
      v_o[p] = '0;
      if (inst_valid && rs_a[p] != '0) begin
        q_o[p] = tag_q[rs_a[p]];
        if (q_o[p] == '0) begin
          v_o[p] = val_q[rs_a[p]];
        end
`ifdef REGFILE_BYPASS_EN
        if (rdy_in && q_o[p] != '0) begin
          for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_valid[k] &&
                wb_tag[k*TAG_W +: TAG_W] == tag_q[rs_a[p]]) begin
              v_o[p] = wb_val[k*XLEN +: XLEN];
              q_o[p] = '0;
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Randomised self-checking bench for regfile_rename.
// Reference model tracks the register file as plain arrays.
module tb_regfile_rename;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int TW   = 4;
  localparam int NWB  = 2;
  localparam int RW   = $clog2(NR);

  logic            clk_in = 0;
  logic            rst_in = 0;
  logic            rdy_in = 1;
  logic            inst_valid = 0;
  logic [RW-1:0]   rs1 = 0, rs2 = 0, rd = 0;
  logic [TW-1:0]   rd_tag = 0;
  logic [NWB-1:0]  wb_valid;
  logic [NWB*TW-1:0]   wb_tag;
  logic [NWB*XLEN-1:0] wb_val;
  logic            flush_in = 0;
  logic [XLEN-1:0] vj, vk;
  logic [TW-1:0]   qj, qk;
  logic [RW:0]     busy_cnt;

  logic            wbv [NWB];
  logic [TW-1:0]   wbt [NWB];
  logic [XLEN-1:0] wbd [NWB];

  logic [XLEN-1:0] m_val [NR];
  logic [TW-1:0]   m_tag [NR];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_rename #(
    .XLEN(XLEN), .NUM_REGS(NR), .TAG_W(TW), .NUM_WB(NWB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_valid(inst_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rd_tag(rd_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_val(wb_val), .flush_in(flush_in),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk), .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  always_comb begin
    wb_valid = '0;
    wb_tag   = '0;
    wb_val   = '0;
    for (int k = 0; k < NWB; k++) begin
      wb_valid[k] = wbv[k];
      wb_tag[k*TW +: TW] = wbt[k];
      wb_val[k*XLEN +: XLEN] = wbd[k];
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endfunction

  function automatic int model_busy();
    int c = 0;
    for (int i = 1; i < NR; i++) if (m_tag[i] != 0) c++;
    return c;
  endfunction

  function automatic void model_read(input int rs,
                                     output logic [XLEN-1:0] v,
                                     output logic [TW-1:0] q);
    v = '0;
    q = '0;
    if (!inst_valid || rs == 0) return;
    q = m_tag[rs];
    if (q == 0) v = m_val[rs];
`ifdef REGFILE_BYPASS_EN
    if (rdy_in && q != 0) begin
      for (int k = 0; k < NWB; k++) begin
        if (wbv[k] && wbt[k] == q) begin
          v = wbd[k];
          q = '0;
          break;
        end
      end
    end
`endif
  endfunction

  function automatic void model_commit();
    logic [TW-1:0] old_tag [NR];
    if (!rdy_in) return;
    old_tag = m_tag;
    for (int i = 1; i < NR; i++) begin
      for (int k = 0; k < NWB; k++) begin
        if (wbv[k] && wbt[k] != 0 && old_tag[i] == wbt[k]) begin
          m_val[i] = wbd[k];
          m_tag[i] = '0;
          break;
        end
      end
    end
    if (flush_in) begin
      for (int i = 0; i < NR; i++) m_tag[i] = '0;
    end else if (inst_valid && rd != 0) begin
      m_tag[rd] = rd_tag;
    end
  endfunction

  // Check reads mid-cycle, clock, update model, check busy_cnt
  task automatic cycle();
    logic [XLEN-1:0] ev;
    logic [TW-1:0]   eq;
    @(negedge clk_in);
    model_read(int'(rs1), ev, eq);
    chk("vj", 64'(vj), 64'(ev));
    chk("qj", 64'(qj), 64'(eq));
    model_read(int'(rs2), ev, eq);
    chk("vk", 64'(vk), 64'(ev));
    chk("qk", 64'(qk), 64'(eq));
    @(posedge clk_in);
    model_commit();
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(model_busy()));
  endtask

  task automatic idle();
    inst_valid = 0; rd = 0; rd_tag = 0; flush_in = 0; rdy_in = 1;
    for (int k = 0; k < NWB; k++) begin
      wbv[k] = 0; wbt[k] = 0; wbd[k] = 0;
    end
  endtask

  task automatic ren(input int r, input int t);
    inst_valid = 1; rd = RW'(r); rd_tag = TW'(t);
  endtask

  task automatic wb(input int ch, input int t, input logic [XLEN-1:0] d);
    wbv[ch] = 1; wbt[ch] = TW'(t); wbd[ch] = d;
  endtask

  initial begin
    idle();
    model_reset();
    inst_valid = 1; rs1 = 3; rs2 = 4;
    #2;
    chk("rst_qj", 64'(qj), 64'd0);
    chk("rst_vj", 64'(vj), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);
    @(negedge clk_in);
    rst_in = 1;
    @(posedge clk_in); #1;

    // build tag[5]=3, val[5]=0xAA via rename beating writeback
    idle(); ren(5, 2); cycle();
    idle(); ren(5, 3); wb(0, 2, 32'hAA); cycle();
    idle(); inst_valid = 1; rs1 = 5; rs2 = 0; #2;
    chk("r5_tag", 64'(qj), 64'd3);
    chk("r5_busy", 64'(busy_cnt), 64'd1);
    rst_in = 0; #1;
    chk("mid_rst_qj", 64'(qj), 64'd0);
    chk("mid_rst_vj", 64'(vj), 64'd0);
    chk("mid_rst_busy", 64'(busy_cnt), 64'd0);
    model_reset();
    #1 rst_in = 1;
    @(posedge clk_in); #1;

    // rename then retire on channel 1
    idle(); ren(7, 4); cycle();
    idle(); wb(1, 4, 32'h1234); cycle();
    idle(); inst_valid = 1; rs1 = 7; #2;
    chk("retire_qj", 64'(qj), 64'd0);
    chk("retire_vj", 64'(vj), 64'h1234);
    chk("retire_busy", 64'(busy_cnt), 64'd0);
    cycle();

    // one writeback retiring two registers
    idle(); ren(2, 6); cycle();
    idle(); ren(9, 6); cycle();
    chk("multi_busy_pre", 64'(busy_cnt), 64'd2);
    idle(); wb(0, 6, 32'h55); cycle();
    idle(); inst_valid = 1; rs1 = 2; rs2 = 9; #2;
    chk("multi_vj", 64'(vj), 64'h55);
    chk("multi_vk", 64'(vk), 64'h55);
    chk("multi_busy", 64'(busy_cnt), 64'd0);
    cycle();

    // rdy_in low freezes rename
    idle(); ren(6, 7); rdy_in = 0; cycle();
    idle(); inst_valid = 1; rs1 = 6; #2;
    chk("frozen_qj", 64'(qj), 64'd0);
    cycle();

    // rename and writeback on the same rd, then flush with rename
    idle(); ren(3, 2); cycle();
    idle(); ren(3, 5); wb(0, 2, 32'h77); cycle();
    idle(); ren(1, 7); cycle();
    idle(); ren(10, 8); cycle();
    idle(); ren(11, 10); cycle();
    idle(); inst_valid = 1; rs1 = 3; #2;
    chk("same_rd_qj", 64'(qj), 64'd5);
    chk("flush_busy_pre", 64'(busy_cnt), 64'd4);
    idle(); ren(8, 1); flush_in = 1; cycle();
    idle(); inst_valid = 1; rs1 = 3; rs2 = 8; #2;
    chk("flush_busy", 64'(busy_cnt), 64'd0);
    chk("same_rd_val", 64'(vj), 64'h77);
    chk("flush_qk", 64'(qk), 64'd0);
    cycle();

    // same-cycle forwarding
    idle(); ren(4, 9); cycle();
    idle(); inst_valid = 1; rs2 = 4; rs1 = 0; wb(0, 9, 32'hBEEF); #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_qk", 64'(qk), 64'd0);
    chk("byp_vk", 64'(vk), 64'hBEEF);
`else
    chk("byp_qk", 64'(qk), 64'd9);
    chk("byp_vk", 64'(vk), 64'd0);
`endif
    cycle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      inst_valid = ($urandom_range(0, 3) != 0);
      rs1 = RW'($urandom_range(0, NR-1));
      rs2 = RW'($urandom_range(0, NR-1));
      rd = RW'($urandom_range(0, NR-1));
      rd_tag = TW'($urandom_range(0, (1<<TW)-1));
      flush_in = ($urandom_range(0, 24) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NWB; k++) begin
        logic [TW-1:0] t;
        logic dup;
        t = m_tag[$urandom_range(1, NR-1)];
        if (t == 0 || $urandom_range(0, 3) == 0)
          t = TW'($urandom_range(0, (1<<TW)-1));
        dup = 0;
        for (int j = 0; j < k; j++)
          if (wbv[j] && wbt[j] == t) dup = 1;
        wbv[k] = ($urandom_range(0, 1) == 1) && !dup;
        wbt[k] = t;
        wbd[k] = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
